serial_word_feeder: RTL and testbench
=====================================

SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of bits per word; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream word available.
REQ-005 SHALL have port: in_word  input  WIDTH  parallel word; bit WIDTH-1 is MSB.
REQ-006 SHALL have port: in_ready  output  1  feeder accepts in_word on this edge when in_valid=1.
REQ-007 SHALL have port: stall  input  1  downstream hold request; freezes shifting.
REQ-008 SHALL have port: clr_out  output  1  one-cycle synchronous clear for the downstream serial divisibility checker.
REQ-009 SHALL have port: bit_out  output  1  current serial bit, MSB first.
REQ-010 SHALL have port: bit_valid  output  1  bit_out is meaningful this cycle.
REQ-011 SHALL have port: bit_last  output  1  bit_out is the LSB of the current word.

Function
REQ-012 SHALL implement FSM states IDLE, CLR, SHIFT.
REQ-013 SHALL drive in_ready=1 in IDLE, and in SHIFT only when bit_last=1 and stall=0; otherwise in_ready=0.
REQ-014 SHALL accept a word on any edge where in_valid=1 and in_ready=1, capturing in_word into the shift register and moving to CLR.
REQ-015 SHALL, in CLR, assert clr_out=1 and bit_valid=0 for exactly one cycle regardless of stall, then enter SHIFT.
REQ-016 SHALL, in SHIFT, assert bit_valid=1 with bit_out = current MSB of the shift register.
REQ-017 SHALL, on each SHIFT edge with stall=0, shift the register left by one bit and decrement a remaining-bit counter loaded with WIDTH at acceptance.
REQ-018 SHALL, on SHIFT edges with stall=1, hold the register, counter, bit_out, bit_valid and bit_last unchanged.
REQ-019 SHALL assert bit_last=1 only in SHIFT when the remaining count equals 1.
REQ-020 SHALL, on the last-bit edge with stall=0, go to CLR if a word is accepted on that edge, else to IDLE.
REQ-021 SHALL give latency: word accepted at edge T -> clr_out high in cycle T+1, bits in cycles T+2..T+1+WIDTH when unstalled.
REQ-022 SHALL ignore in_valid while in_ready=0; in_word is not sampled.
REQ-023 SHALL drive clr_out=0, bit_valid=0, bit_last=0 and bit_out=0 in IDLE.

Reset
REQ-024 SHALL, when reset=1 at an edge, enter IDLE, clear the shift register and counter, and discard any in-flight word.
REQ-025 SHALL give reset values: in_ready=1 after the reset edge releases, clr_out=0, bit_out=0, bit_valid=0, bit_last=0.
REQ-026 SHALL give reset priority over in_valid and stall on the same edge.

Structure
REQ-027 SHALL place the FSM state typedef (IDLE/CLR/SHIFT) in a shared package, alongside the WIDTH range limits.
REQ-028 SHALL size the counter as clog2(WIDTH)+1 bits.
REQ-029 SHALL use one sub-module, piso_shreg, for the loadable left-shifting register with hold enable; the FSM stays in the top module.

Verification
REQ-030 SHALL verify: WIDTH=8, in_word=8'h06 accepted at T -> clr_out at T+1, bit_out 0,0,0,0,0,1,1,0 in T+2..T+9, bit_last only at T+9; a downstream divisibility checker reports divisible at T+9.
REQ-031 SHALL verify: words 8'h07 then 8'h09 with in_valid held high -> second word accepted on the 8'h07 bit_last edge, clr_out in the next cycle, no IDLE cycle between frames.
REQ-032 SHALL verify: stall=1 for 3 cycles during bit 4 of 8'hA5 -> bit_out=0 (MSB-first bit 4) held 4 cycles, total frame 11 bit_valid cycles, order unchanged.
REQ-033 SHALL verify: reset=1 during bit 3 of 8'hFF -> next cycle IDLE, bit_valid=0, in_ready=1; a following word 8'h03 streams correctly.
REQ-034 SHALL verify: in_valid=1 with in_word=8'h55 while mid-frame -> word not captured; the current frame completes unaltered.
REQ-035 SHALL verify: stall=1 during CLR -> clr_out still lasts exactly one cycle, and the first bit appears in the following cycle, held while stall remains 1.

Source files
------------

// File: rtl/serial_word_feeder_pkg.sv
// Shared types and limits for the serial word feeder.
package serial_word_feeder_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/piso_shreg.sv
// Loadable left-shifting register with hold; exposes the current MSB.
module piso_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load wins over shift so a back-to-back word replaces the drained one.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_word_feeder.sv
// Serialises parallel words MSB first, preceded by a one-cycle downstream clear.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  output logic             in_ready,
  input  logic             stall,
  output logic             clr_out,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_word_feeder: WIDTH out of range");
  end

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          load;
  logic          shift;
  logic          msb;
  logic          last;

  assign last = (state_q == SHIFT) && (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and register control; acceptance reloads the counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift    = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = CW'(WIDTH);
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (!stall) begin
          shift = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (last) begin
            in_ready = 1'b1;
            if (in_valid) begin
              load    = 1'b1;
              cnt_d   = CW'(WIDTH);
              state_d = CLR;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .shift_i(shift),
    .din_i  (in_word),
    .msb_o  (msb)
  );

  // Outputs decode directly from registered state.
  assign clr_out   = (state_q == CLR);
  assign bit_valid = (state_q == SHIFT);
  assign bit_last  = last;
  assign bit_out   = (state_q == SHIFT) ? msb : 1'b0;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Randomised and directed self-checking bench for serial_word_feeder.
module tb_serial_word_feeder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_word;
  logic         in_ready;
  logic         stall;
  logic         clr_out;
  logic         bit_out;
  logic         bit_valid;
  logic         bit_last;

  int n_tests = 0;
  int n_fail  = 0;

  serial_word_feeder #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_word  (in_word),
    .in_ready (in_ready),
    .stall    (stall),
    .clr_out  (clr_out),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .bit_last (bit_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Frame-level model: a busy flag, a clear phase and the index of the bit on the wire.
  bit           m_busy = 1'b0;
  bit           m_clr  = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_pos  = 0;
  bit           chk_en = 1'b0;

  function automatic bit e_valid();
    return m_busy && !m_clr;
  endfunction

  function automatic bit e_last();
    return e_valid() && (m_pos == int'(W) - 1);
  endfunction

  function automatic bit e_bit();
    return e_valid() ? m_word[int'(W) - 1 - m_pos] : 1'b0;
  endfunction

  function automatic bit e_ready();
    return !m_busy || (e_last() && !stall);
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = in_valid && e_ready();
    if (reset) begin
      m_busy = 1'b0;
      m_clr  = 1'b0;
      m_pos  = 0;
    end else begin
      if (m_clr) begin
        m_clr = 1'b0;
      end else if (m_busy && !stall) begin
        if (m_pos == int'(W) - 1) m_busy = 1'b0;
        else m_pos++;
      end
      if (acc) begin
        m_busy = 1'b1;
        m_clr  = 1'b1;
        m_word = in_word;
        m_pos  = 0;
      end
    end
  end

  // Downstream divide-by-3 checker fed from the DUT's serial stream.
  int d_rem = 0;
  always @(posedge clk) begin
    if (reset || clr_out) d_rem = 0;
    else if (bit_valid && !stall) d_rem = (d_rem * 2 + int'(bit_out)) % 3;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_clr_out",   int'(clr_out),   int'(m_clr));
      chk("m_bit_valid", int'(bit_valid), int'(e_valid()));
      chk("m_bit_last",  int'(bit_last),  int'(e_last()));
      chk("m_bit_out",   int'(bit_out),   int'(e_bit()));
      chk("m_in_ready",  int'(in_ready),  int'(e_ready()));
    end
  end

  // Returns just after the accepting edge, i.e. in the clear cycle.
  task automatic accept_word(input logic [W-1:0] w, input bit keep);
    bit r;
    r        = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    if (!keep) in_valid = 1'b0;
    if (!r) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for word %0h", w);
    end
  endtask

  task automatic check_frame(input logic [W-1:0] w, input string tag);
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      chk({tag, "_valid"}, int'(bit_valid), 1);
      chk({tag, "_bit"},   int'(bit_out),   int'(w[int'(W) - 1 - i]));
      chk({tag, "_last"},  int'(bit_last),  int'(i == int'(W) - 1));
    end
  endtask

  int exp_a [8]  = '{0, 0, 0, 0, 0, 1, 1, 0};
  int exp_d [11] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
  int exp_e [8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
  int seq   [16];
  int n_seq;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_word  = '0;
    stall    = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_clr_out",   int'(clr_out),   0);
    chk("rst_bit_out",   int'(bit_out),   0);
    chk("rst_bit_valid", int'(bit_valid), 0);
    chk("rst_bit_last",  int'(bit_last),  0);
    @(posedge clk); #1;

    // 8'h06: latency, pattern and divisible-by-3 on the last bit
    accept_word(8'h06, 1'b0);
    @(negedge clk);
    chk("a_clr", int'(clr_out), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("a_bit",  int'(bit_out),  exp_a[i]);
      chk("a_last", int'(bit_last), int'(i == 7));
      if (i == 7) chk("a_div3", int'(((d_rem * 2 + int'(bit_out)) % 3) == 0), 1);
    end
    @(posedge clk); #1;

    // back-to-back 8'h07 then 8'h09
    accept_word(8'h07, 1'b1);
    in_word = 8'h09;
    @(negedge clk);
    chk("b_clr1", int'(clr_out), 1);
    check_frame(8'h07, "b_w1");
    chk("b_rdy_last", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b_clr2",   int'(clr_out),   1);
    chk("b_noidle", int'(bit_valid), 0);
    check_frame(8'h09, "b_w2");
    @(posedge clk); #1;

    // 8'hA5 with a 3-cycle stall on bit 4
    accept_word(8'hA5, 1'b0);
    n_seq = 0;
    fork
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (bit_valid) begin
            if (n_seq < 16) seq[n_seq] = int'(bit_out);
            n_seq++;
            if (bit_last && !stall) break;
          end
        end
      end
      begin
        repeat (5) begin @(posedge clk); #1; end
        stall = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        stall = 1'b0;
      end
    join
    chk("d_count", n_seq, 11);
    for (int i = 0; i < 11; i++) chk("d_seq", seq[i], exp_d[i]);
    @(posedge clk); #1;

    // reset during bit 3 of 8'hFF, then 8'h03
    accept_word(8'hFF, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("e_valid", int'(bit_valid), 0);
    chk("e_ready", int'(in_ready),  1);
    chk("e_clr",   int'(clr_out),   0);
    @(posedge clk); #1;
    accept_word(8'h03, 1'b0);
    @(negedge clk);
    chk("e_clr2", int'(clr_out), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("e_bit", int'(bit_out), exp_e[i]);
    end
    @(posedge clk); #1;

    // 8'h55 offered mid-frame of 8'hC3 is ignored
    accept_word(8'hC3, 1'b0);
    fork
      begin
        @(negedge clk);
        chk("f_clr", int'(clr_out), 1);
        check_frame(8'hC3, "f");
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_word  = 8'h55;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
      end
    join
    @(negedge clk);
    chk("f_idle_clr",   int'(clr_out),   0);
    chk("f_idle_valid", int'(bit_valid), 0);
    @(posedge clk); #1;

    // stall across the clear cycle of 8'h81
    accept_word(8'h81, 1'b0);
    stall = 1'b1;
    @(negedge clk);
    chk("g_clr", int'(clr_out), 1);
    @(negedge clk);
    chk("g_clr_once", int'(clr_out),   0);
    chk("g_valid1",   int'(bit_valid), 1);
    chk("g_bit1",     int'(bit_out),   1);
    @(negedge clk);
    chk("g_valid2", int'(bit_valid), 1);
    chk("g_bit2",   int'(bit_out),   1);
    chk("g_last2",  int'(bit_last),  0);
    @(posedge clk); #1;
    stall = 1'b0;
    check_frame(8'h81, "g");
    @(posedge clk); #1;

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_word  = W'($urandom());
      stall    = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b0;
    repeat (12) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
